// File: rtl/snpu_mac_sequencer_if.sv
// rtl/snpu_mac_sequencer_if.sv - command, register-file, MAC and result signals of the SNPU sequencer
interface snpu_mac_sequencer_if #(
  parameter int AW    = 2,
  parameter int ACC_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic             wr_en;
  logic             wr_sel;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       wr_data;
  logic             mac_clr;
  logic             mac_en;
  logic [AW-1:0]    mac_idx;
  logic [ACC_W-1:0] acc_in;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;

  modport master (
    input  cmd_valid, cmd_data, acc_in, res_ready,
    output cmd_ready, wr_en, wr_sel, wr_addr, wr_data,
           mac_clr, mac_en, mac_idx, res_valid, res_data
  );

  modport slave (
    output cmd_valid, cmd_data, acc_in, res_ready,
    input  cmd_ready, wr_en, wr_sel, wr_addr, wr_data,
           mac_clr, mac_en, mac_idx, res_valid, res_data
  );
endinterface

// File: rtl/snpu_mac_sequencer.sv
// rtl/snpu_mac_sequencer.sv - SNPU command parser, MAC stepper and int8 requantiser
// Defining SNPU_RELU_EN adds the optional ReLU clamp selected by RUN bit 4.
module snpu_mac_sequencer #(
  parameter int N_LANES = 4,
  parameter int ACC_W   = 20,
  parameter int AW      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  snpu_mac_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CLR, MAC, DRAIN, OUT} state_t;

  localparam logic [AW-1:0]           LAST   = AW'(N_LANES - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

  state_t                  state, state_nxt;
  logic [AW-1:0]           cnt, cnt_nxt;
  logic                    sel, sel_nxt;
  logic [3:0]              shift, shift_nxt;
  logic [7:0]              res_q, res_nxt;
  logic signed [ACC_W-1:0] acc_sh;
  logic [7:0]              res_sat;
  logic                    cmd_ready, wr_en, mac_clr, mac_en;
`ifdef SNPU_RELU_EN
  logic                    relu, relu_nxt;
`endif

  assign acc_sh = $signed(bus.acc_in) >>> shift;

  always_comb begin
    if (acc_sh > SAT_HI)      res_sat = 8'h7f;
    else if (acc_sh < SAT_LO) res_sat = 8'h80;
    else                      res_sat = acc_sh[7:0];
`ifdef SNPU_RELU_EN
    if (relu && acc_sh[ACC_W-1]) res_sat = 8'h00;
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    shift_nxt = shift;
    res_nxt   = res_q;
`ifdef SNPU_RELU_EN
    relu_nxt  = relu;
`endif
    cmd_ready = 1'b0;
    wr_en     = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    // With ena low every strobe stays 0 and all *_nxt keep their hold value.
    if (ena) begin
      case (state)
        IDLE: begin
          cmd_ready = rst_n;
          if (bus.cmd_valid && cmd_ready) begin
            case (bus.cmd_data[7:6])
              2'b00, 2'b01: begin
                state_nxt = LOAD;
                cnt_nxt   = '0;
                sel_nxt   = bus.cmd_data[6];
              end
              2'b10: begin
                state_nxt = CLR;
                shift_nxt = bus.cmd_data[3:0];
`ifdef SNPU_RELU_EN
                relu_nxt  = bus.cmd_data[4];
`endif
              end
              default: ;
            endcase
          end
        end
        LOAD: begin
          cmd_ready = rst_n;
          if (bus.cmd_valid && cmd_ready) begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) state_nxt = IDLE;
          end
        end
        CLR: begin
          mac_clr   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = MAC;
        end
        MAC: begin
          mac_en  = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = DRAIN;
        end
        DRAIN: begin
          res_nxt   = res_sat;
          state_nxt = OUT;
        end
        OUT: begin
          if (bus.res_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
      shift <= '0;
      res_q <= '0;
`ifdef SNPU_RELU_EN
      relu  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      shift <= shift_nxt;
      res_q <= res_nxt;
`ifdef SNPU_RELU_EN
      relu  <= relu_nxt;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_sel    = sel;
  assign bus.wr_addr   = wr_en ? cnt : '0;
  assign bus.wr_data   = wr_en ? bus.cmd_data : 8'h00;
  assign bus.mac_clr   = mac_clr;
  assign bus.mac_en    = mac_en;
  assign bus.mac_idx   = (state == MAC) ? cnt : '0;
  assign bus.res_valid = (state == OUT);
  assign bus.res_data  = res_q;
endmodule

// File: tb/tb_snpu_mac_sequencer.sv
// tb/tb_snpu_mac_sequencer.sv - scoreboard bench for snpu_mac_sequencer with a behavioural MAC datapath
module tb_snpu_mac_sequencer;
  localparam int N_LANES = 4;
  localparam int ACC_W   = 20;
  localparam int AW      = 2;
  // cycles from the one after RUN acceptance to the first res_valid cycle
  localparam int RES_LAT = N_LANES + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;

  snpu_mac_sequencer_if #(.AW(AW), .ACC_W(ACC_W)) bus ();

  snpu_mac_sequencer #(.N_LANES(N_LANES), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int run_cyc = 0;
  logic [7:0] exp_q[$];
  int w_mem[N_LANES];
  int x_mem[N_LANES];

  logic signed [7:0]       w_rf[N_LANES];
  logic signed [7:0]       x_rf[N_LANES];
  logic signed [ACC_W-1:0] acc;
  assign bus.acc_in = acc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    int p;
    if (!rst_n) acc <= '0;
    else begin
      p = int'(w_rf[bus.mac_idx]) * int'(x_rf[bus.mac_idx]);
      if (bus.mac_clr)     acc <= '0;
      else if (bus.mac_en) acc <= acc + ACC_W'(p);
      if (bus.wr_en) begin
        if (bus.wr_sel) x_rf[bus.wr_addr] <= bus.wr_data;
        else            w_rf[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  int wr_cnt = 0, mac_cnt = 0, mac_run = 0, mac_run_max = 0, mac_pos = 0, idx_err = 0;
  always @(posedge clk) begin
    if (bus.wr_en) wr_cnt++;
    if (bus.mac_clr) mac_pos = 0;
    if (bus.mac_en) begin
      if (int'(bus.mac_idx) != mac_pos) idx_err++;
      mac_pos++;
      mac_cnt++;
      mac_run++;
      if (mac_run > mac_run_max) mac_run_max = mac_run;
    end else mac_run = 0;
  end

  function automatic logic [7:0] model(input logic [7:0] op);
    int s = 0;
    int y;
    for (int i = 0; i < N_LANES; i++) s += w_mem[i] * x_mem[i];
    y = s >>> op[3:0];
    if (y > 127) y = 127;
    else if (y < -128) y = -128;
`ifdef SNPU_RELU_EN
    if (op[4] && y < 0) y = 0;
`endif
    return y[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!bus.cmd_ready) begin
      miscompares++;
      $display("FAIL cmd_accept byte=%02h: cmd_ready=%0b, required 1 within 50 cycles", b, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic load(input bit is_x, input logic [31:0] vals);
    send_byte(is_x ? 8'h40 : 8'h00);
    for (int i = 0; i < N_LANES; i++) begin
      if (is_x) x_mem[i] = int'($signed(vals[8*i +: 8]));
      else      w_mem[i] = int'($signed(vals[8*i +: 8]));
      send_byte(vals[8*i +: 8]);
    end
  endtask

  task automatic run(input logic [7:0] op);
    exp_q.push_back(model(op));
    send_byte(op);
    run_cyc = acc_cyc;
  endtask

  task automatic get_result(input string name, input int lat, input int hold);
    int n = 0;
    logic [7:0] want;
    @(negedge clk);
    while (!bus.res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!bus.res_valid) begin
      miscompares++;
      $display("FAIL %s_timeout: res_valid=0 after 60 cycles, required 1", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (lat >= 0) begin
      vectors++;
      if (cyc - run_cyc !== lat) begin
        miscompares++;
        $display("FAIL %s_latency: res_valid after %0d cycles, required %0d", name, cyc - run_cyc, lat);
      end
    end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    vectors++;
    if (bus.res_data !== want) begin
      miscompares++;
      $display("FAIL %s_data: res_data=%02h, required %02h", name, bus.res_data, want);
    end
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h00;
      #1;
      vectors++;
      if ({bus.res_valid, bus.res_data, bus.cmd_ready, bus.wr_en} !== {1'b1, want, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL %s_hold%0d: valid/data/cmd_ready/wr_en=%0b/%02h/%0b/%0b, required 1/%02h/0/0",
                 name, i, bus.res_valid, bus.res_data, bus.cmd_ready, bus.wr_en, want);
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    vectors++;
    if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s_release: res_valid/cmd_ready=%0b/%0b, required 0/1", name, bus.res_valid, bus.cmd_ready);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.cmd_ready, bus.wr_en, bus.wr_sel, bus.wr_addr, bus.wr_data,
                bus.mac_clr, bus.mac_en, bus.mac_idx, bus.res_valid, bus.res_data});
  endfunction

  task automatic test_reset();
    ena = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h55;
    repeat (3) @(negedge clk);
    vectors++;
    if (all_outs() !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: outputs=%08h, required 00000000", all_outs());
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_idle: cmd_ready/res_valid=%0b/%0b, required 1/0", bus.cmd_ready, bus.res_valid);
    end
  endtask

  task automatic test_load_run();
    int wr0, mac0;
    wr0 = wr_cnt;
    load(1'b0, 32'h04030201);
    load(1'b1, 32'h01010101);
    vectors++;
    if (wr_cnt - wr0 !== 8) begin
      miscompares++;
      $display("FAIL t1_wr_pulses: %0d, required 8", wr_cnt - wr0);
    end
    mac0 = mac_cnt;
    mac_run_max = 0;
    idx_err = 0;
    run(8'h80);
    get_result("t1", RES_LAT, 0);
    vectors++;
    if ({mac_cnt - mac0, mac_run_max, idx_err} !== {32'd4, 32'd4, 32'd0}) begin
      miscompares++;
      $display("FAIL t1_mac_steps: count/run/idx_err=%0d/%0d/%0d, required 4/4/0",
               mac_cnt - mac0, mac_run_max, idx_err);
    end
  endtask

  task automatic test_abort_idle();
    int wr0 = wr_cnt, mac0 = mac_cnt;
    send_byte(8'hc0);
    repeat (8) @(negedge clk);
    vectors++;
    if ({bus.cmd_ready, bus.res_valid, wr_cnt == wr0, mac_cnt == mac0} !== 4'b1011) begin
      miscompares++;
      $display("FAIL abort_idle: cmd_ready/res_valid/wr_quiet/mac_quiet=%0b/%0b/%0b/%0b, required 1/0/1/1",
               bus.cmd_ready, bus.res_valid, wr_cnt == wr0, mac_cnt == mac0);
    end
  endtask

  task automatic test_saturation();
    load(1'b0, 32'h7f7f7f7f);
    load(1'b1, 32'h7f7f7f7f);
    run(8'h80);
    get_result("t2_pos_sat", RES_LAT, 0);
    load(1'b0, 32'h80808080);
    run(8'h82);
    get_result("t3_neg_sat", RES_LAT, 0);
    run(8'h92);
    get_result("t3_relu", RES_LAT, 0);
    run(8'h8a);
    get_result("shift10", RES_LAT, 0);
    run(8'h8f);
    get_result("shift15", RES_LAT, 0);
  endtask

  task automatic test_backpressure();
    run(8'h80);
    get_result("t4_stall", RES_LAT, 5);
  endtask

  task automatic test_reset_mid_mac();
    int n = 0;
    send_byte(8'h82);
    @(negedge clk);
    while (!(bus.mac_en && bus.mac_idx == 2'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== 32'h0) begin
      miscompares++;
      $display("FAIL t5_async_reset: outputs=%08h, required 00000000", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL t5_after_reset: cmd_ready/res_valid=%0b/%0b, required 1/0", bus.cmd_ready, bus.res_valid);
    end
    run(8'h82);
    get_result("t5_old_rf", RES_LAT, 0);
  endtask

  task automatic test_ena_freeze();
    int n = 0;
    @(negedge clk);
    ena = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h80;
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.wr_en, bus.mac_clr} !== 3'b000) begin
      miscompares++;
      $display("FAIL ena_idle: cmd_ready/wr_en/mac_clr=%0b/%0b/%0b, required 0/0/0",
               bus.cmd_ready, bus.wr_en, bus.mac_clr);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    ena = 1'b1;
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.mac_clr} !== 2'b10) begin
      miscompares++;
      $display("FAIL ena_idle_resume: cmd_ready/mac_clr=%0b/%0b, required 1/0", bus.cmd_ready, bus.mac_clr);
    end
    load(1'b0, 32'h04030201);
    load(1'b1, 32'h01010101);
    run(8'h80);
    @(negedge clk);
    while (!(bus.mac_en && bus.mac_idx == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.mac_en, bus.mac_idx, bus.cmd_ready} !== {1'b0, 2'd1, 1'b0}) begin
        miscompares++;
        $display("FAIL t6_frozen%0d: mac_en/mac_idx/cmd_ready=%0b/%0d/%0b, required 0/1/0",
                 i, bus.mac_en, bus.mac_idx, bus.cmd_ready);
      end
      @(negedge clk);
    end
    ena = 1'b1;
    get_result("t6_ena", RES_LAT + 3, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_load_run();
    test_abort_idle();
    test_saturation();
    test_backpressure();
    test_reset_mid_mac();
    test_ena_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
